// File: rtl/wb_commit_buf_pkg.sv
// Shared types and constants for the writeback commit buffer.
// WB_HILO_EN controls whether address 32 (HI/LO) is stored or dropped.
package wb_commit_buf_pkg;

  localparam logic [5:0] HILO_ADDR = 6'd32;
  localparam logic [5:0] ZERO_ADDR = 6'd0;
  localparam int         WB_PORTS  = 4;

  typedef struct packed {
    logic [5:0]  addr;
    logic [63:0] data;
  } wb_entry_t;

  function automatic logic addr_storable(input logic [5:0] a);
`ifdef WB_HILO_EN
    return (a != ZERO_ADDR);
`else
    return (a != ZERO_ADDR) && (a != HILO_ADDR);
`endif
  endfunction

endpackage

// File: rtl/wb_commit_buf_if.sv
// Result-input and register-file-write bundle of the commit buffer.
interface wb_commit_buf_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in0_valid;
  logic          in1_valid;
  logic [5:0]    in0_addr;
  logic [5:0]    in1_addr;
  logic [63:0]   in0_data;
  logic [63:0]   in1_data;
  logic          in_ready;
  logic          we0, we1, we2, we3;
  logic [5:0]    waddr0, waddr1, waddr2, waddr3;
  logic [63:0]   wdata0, wdata1, wdata2, wdata3;
  logic [CW-1:0] count;

  modport master (
    output flush, in0_valid, in1_valid, in0_addr, in1_addr, in0_data, in1_data,
    input  in_ready, we0, we1, we2, we3, waddr0, waddr1, waddr2, waddr3,
           wdata0, wdata1, wdata2, wdata3, count
  );

  modport slave (
    input  flush, in0_valid, in1_valid, in0_addr, in1_addr, in0_data, in1_data,
    output in_ready, we0, we1, we2, we3, waddr0, waddr1, waddr2, waddr3,
           wdata0, wdata1, wdata2, wdata3, count
  );

endinterface

// File: rtl/wb_group_sel.sv
// Chooses how many head entries can be written to the register file this cycle.
// Address 32 may only take port 0 when WB_HILO_EN is defined.
module wb_group_sel
  import wb_commit_buf_pkg::*;
#(
  parameter int CW = 4
) (
  input  wb_entry_t       win_i [WB_PORTS],
  input  logic [CW-1:0]   count_i,
  output logic [2:0]      size_o
);

  logic stop;
  logic hit;

  always_comb begin
    size_o = 3'd0;
    stop   = 1'b0;
    hit    = 1'b0;
    for (int k = 0; k < WB_PORTS; k++) begin
      hit = (k >= int'(count_i));
      // Two writes to one address in a cycle would lose the older one.
      for (int j = 0; j < k; j++) begin
        if (win_i[j].addr == win_i[k].addr) hit = 1'b1;
      end
`ifdef WB_HILO_EN
      if ((k != 0) && (win_i[k].addr == HILO_ADDR)) hit = 1'b1;
`endif
      if (hit) stop = 1'b1;
      if (!stop) size_o = 3'(k + 1);
    end
  end

endmodule

// File: rtl/wb_commit_buf.sv
// In-order writeback buffer: 2 results in, up to 4 register-file writes out.
// Define WB_HILO_EN to store and steer HI/LO (address 32) results.
module wb_commit_buf
  import wb_commit_buf_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  wb_commit_buf_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          in_ready;
  logic          push0, push1;
  logic [1:0]    n_push;
  logic [2:0]    grp_size, n_pop;
  wb_entry_t     win [WB_PORTS];

  logic          we_q    [WB_PORTS];
  logic          we_d    [WB_PORTS];
  logic [5:0]    waddr_q [WB_PORTS];
  logic [5:0]    waddr_d [WB_PORTS];
  logic [63:0]   wdata_q [WB_PORTS];
  logic [63:0]   wdata_d [WB_PORTS];

  // Ready looks only at the registered count so it never depends on the drain.
  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign push0    = bus.in0_valid && addr_storable(bus.in0_addr) && in_ready && !bus.flush;
  assign push1    = bus.in1_valid && addr_storable(bus.in1_addr) && in_ready && !bus.flush;
  assign n_push   = {1'b0, push0} + {1'b0, push1};

  always_comb begin
    for (int k = 0; k < WB_PORTS; k++) begin
      win[k] = mem_q[head_q + PW'(k)];
    end
  end

  wb_group_sel #(.CW(CW)) u_group_sel (
    .win_i   (win),
    .count_i (count_q),
    .size_o  (grp_size)
  );

  assign n_pop = bus.flush ? 3'd0 : grp_size;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(n_pop);
      tail_d  = tail_q + PW'(n_push);
      count_d = count_q + CW'(n_push) - CW'(n_pop);
    end
  end

  always_comb begin
    for (int k = 0; k < WB_PORTS; k++) begin
      we_d[k]    = !bus.flush && (3'(k) < grp_size);
      waddr_d[k] = we_d[k] ? win[k].addr : 6'd0;
      wdata_d[k] = we_d[k] ? win[k].data : 64'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int k = 0; k < WB_PORTS; k++) begin
        we_q[k]    <= 1'b0;
        waddr_q[k] <= 6'd0;
        wdata_q[k] <= 64'd0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int k = 0; k < WB_PORTS; k++) begin
        we_q[k]    <= we_d[k];
        waddr_q[k] <= waddr_d[k];
        wdata_q[k] <= wdata_d[k];
      end
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push0) mem_q[tail_q] <= '{addr: bus.in0_addr, data: bus.in0_data};
    if (push1) mem_q[tail_q + PW'(push0)] <= '{addr: bus.in1_addr, data: bus.in1_data};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (CW'(DEPTH) - count_q) >= CW'(n_push));

  assign bus.in_ready = in_ready;
  assign bus.count    = count_q;
  assign bus.we0      = we_q[0];
  assign bus.we1      = we_q[1];
  assign bus.we2      = we_q[2];
  assign bus.we3      = we_q[3];
  assign bus.waddr0   = waddr_q[0];
  assign bus.waddr1   = waddr_q[1];
  assign bus.waddr2   = waddr_q[2];
  assign bus.waddr3   = waddr_q[3];
  assign bus.wdata0   = wdata_q[0];
  assign bus.wdata1   = wdata_q[1];
  assign bus.wdata2   = wdata_q[2];
  assign bus.wdata3   = wdata_q[3];

endmodule

// File: tb/tb_wb_commit_buf.sv
// Bench for wb_commit_buf: directed scenarios plus random traffic against a queue model.
module tb_wb_commit_buf;
  import wb_commit_buf_pkg::*;

  localparam int DEPTH = 8;
`ifdef WB_HILO_EN
  localparam bit HILO_EN = 1'b1;
`else
  localparam bit HILO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_commit_buf_if #(.DEPTH(DEPTH)) bus ();
  wb_commit_buf #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  wb_entry_t   model_q [$];
  logic        exp_we    [4];
  logic [5:0]  exp_waddr [4];
  logic [63:0] exp_wdata [4];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic bit storable(input logic [5:0] a);
    return (a != 6'd0) && (HILO_EN || a != 6'd32);
  endfunction

  // Reference: drain the oldest entries under the write rules, then append accepted inputs.
  task automatic model_step(input bit r, input bit fl,
                            input bit v0, input logic [5:0] a0, input logic [63:0] d0,
                            input bit v1, input logic [5:0] a1, input logic [63:0] d1);
    int         n;
    bit         stop;
    bit         rdy;
    wb_entry_t  e;
    logic [5:0] seen [$];
    for (int k = 0; k < 4; k++) begin
      exp_we[k] = 1'b0; exp_waddr[k] = 6'd0; exp_wdata[k] = 64'd0;
    end
    if (r || fl) begin
      model_q.delete();
      return;
    end
    rdy  = (DEPTH - model_q.size()) >= 2;
    n    = 0;
    stop = 1'b0;
    while (!stop && n < 4 && n < model_q.size()) begin
      e = model_q[n];
      foreach (seen[i]) if (seen[i] == e.addr) stop = 1'b1;
      if (HILO_EN && n > 0 && e.addr == 6'd32) stop = 1'b1;
      if (!stop) begin
        seen.push_back(e.addr);
        n++;
      end
    end
    for (int k = 0; k < n; k++) begin
      e = model_q.pop_front();
      exp_we[k] = 1'b1; exp_waddr[k] = e.addr; exp_wdata[k] = e.data;
    end
    if (rdy) begin
      if (v0 && storable(a0)) model_q.push_back('{addr: a0, data: d0});
      if (v1 && storable(a1)) model_q.push_back('{addr: a1, data: d1});
    end
  endtask

  task automatic check_outputs();
    logic        ow [4];
    logic [5:0]  oa [4];
    logic [63:0] od [4];
    ow = '{bus.we0, bus.we1, bus.we2, bus.we3};
    oa = '{bus.waddr0, bus.waddr1, bus.waddr2, bus.waddr3};
    od = '{bus.wdata0, bus.wdata1, bus.wdata2, bus.wdata3};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("we%0d", k), 64'(ow[k]), 64'(exp_we[k]));
      chk($sformatf("waddr%0d", k), 64'(oa[k]), 64'(exp_waddr[k]));
      chk($sformatf("wdata%0d", k), od[k], exp_wdata[k]);
    end
    chk("count", 64'(bus.count), 64'(model_q.size()));
    chk("in_ready", 64'(bus.in_ready), 64'((DEPTH - model_q.size()) >= 2));
  endtask

  task automatic cycle(input bit r, input bit fl,
                       input bit v0, input logic [5:0] a0, input logic [63:0] d0,
                       input bit v1, input logic [5:0] a1, input logic [63:0] d1);
    rst           = r;
    bus.flush     = fl;
    bus.in0_valid = v0; bus.in0_addr = a0; bus.in0_data = d0;
    bus.in1_valid = v1; bus.in1_addr = a1; bus.in1_data = d1;
    model_step(r, fl, v0, a0, d0, v1, a1, d1);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 6'd0, 64'd0, 0, 6'd0, 64'd0);
  endtask

  function automatic logic [5:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 6'd32;
    return 6'($urandom_range(0, 12));
  endfunction

  initial begin
    int guard;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.in0_valid = 1'b0; bus.in0_addr = '0; bus.in0_data = '0;
    bus.in1_valid = 1'b0; bus.in1_addr = '0; bus.in1_data = '0;

    cycle(1, 0, 0, 6'd0, 64'd0, 0, 6'd0, 64'd0);
    cycle(1, 0, 0, 6'd0, 64'd0, 0, 6'd0, 64'd0);
    chk("rst_we0", 64'(bus.we0), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_ready", 64'(bus.in_ready), 64'd1);

    // Single result.
    cycle(0, 0, 1, 6'd5, 64'h1234, 0, 6'd0, 64'd0);
    idle(1);
    chk("single_we0", 64'(bus.we0), 64'd1);
    chk("single_waddr0", 64'(bus.waddr0), 64'd5);
    chk("single_wdata0", bus.wdata0, 64'h1234);
    idle(1);
    chk("single_count", 64'(bus.count), 64'd0);

    // Same-address pair splits over two cycles.
    cycle(0, 0, 1, 6'd3, 64'hA, 1, 6'd3, 64'hB);
    idle(1);
    chk("waw_first", bus.wdata0, 64'hA);
    chk("waw_we1", 64'(bus.we1), 64'd0);
    idle(1);
    chk("waw_second", bus.wdata0, 64'hB);
    idle(1);

    // HI/LO steering.
    cycle(0, 0, 1, 6'd7, 64'h70, 1, 6'd32, 64'h32);
    cycle(0, 0, 1, 6'd8, 64'h80, 0, 6'd0, 64'd0);
    idle(3);

    // Fill behind a same-address chain, wrap the pointers, then drain.
    for (int i = 0; i < 12; i++)
      cycle(0, 0, 1, 6'd9, 64'(100 + 2 * i), 1, 6'd9, 64'(101 + 2 * i));
    idle(10);

    // Flush at count 6 with a live input.
    guard = 0;
    while (model_q.size() < 6 && guard < 20) begin
      cycle(0, 0, 1, 6'd9, 64'(200 + guard), 1, 6'd9, 64'(300 + guard));
      guard++;
    end
    chk("flush_pre_count", 64'(bus.count), 64'd6);
    cycle(0, 1, 1, 6'd11, 64'hDEAD, 0, 6'd0, 64'd0);
    chk("flush_count", 64'(bus.count), 64'd0);
    idle(3);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      bit r, fl, v0, v1;
      r  = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 39) == 0);
      v0 = ($urandom_range(0, 9) < 7);
      v1 = ($urandom_range(0, 9) < 7);
      cycle(r, fl, v0, rand_addr(), {$urandom, $urandom}, v1, rand_addr(), {$urandom, $urandom});
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
